// File: rtl/stack_pkg.sv
// Shared encodings for the operand stack: command opcodes, push sources and FSM states.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } op_e;

    typedef enum logic {
        SRC_DATA = 1'b0,
        SRC_ALU  = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_RSP  = 2'b10
    } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read with one cycle of latency.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset so the array maps onto a block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack serving push/pop/peek commands from the control unit,
// with registered depth/full/empty status and sticky overflow/underflow flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic              push_src,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              err_clr,
    output logic              cmd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   depth,
    output logic              ovf_err,
    output logic              und_err
);

    localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   sp_q, sp_d, sp_m1;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              und_q, und_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_q;

    assign sp_m1 = sp_q - SP_ONE;

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q & ~err_clr;
        und_d      = und_q & ~err_clr;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = sp_q[ADDR_W-1:0];
        ram_wdata  = (push_src == SRC_ALU) ? alu_result : data_in;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full_q) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_we = 1'b1;
                                sp_d   = sp_q + SP_ONE;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            // Error set takes priority over a coincident err_clr.
                            if (empty_q) begin
                                und_d = 1'b1;
                            end else begin
                                ram_re   = 1'b1;
                                ram_addr = sp_m1[ADDR_W-1:0];
                                state_d  = ST_RD;
                                if (cmd_op == OP_POP) begin
                                    sp_d = sp_m1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RD: begin
                rd_data_d  = ram_q;
                rd_valid_d = 1'b1;
                state_d    = ST_RSP;
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        full_d  = (sp_d == SP_FULL);
        empty_d = (sp_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sp_q       <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign depth     = sp_q;
    assign ovf_err   = ovf_q;
    assign und_err   = und_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed scenario bench for stack_unit: LIFO order, source select, full/empty
// boundaries, peek, command-ignore during reads and reset during a read.
module tb_stack_unit;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_PUSH = 2'b01;
    localparam logic [1:0] C_POP  = 2'b10;
    localparam logic [1:0] C_PEEK = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        push_src;
    logic [15:0] data_in;
    logic [15:0] alu_result;
    logic        err_clr;
    logic        cmd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        full;
    logic        empty;
    logic [5:0]  depth;
    logic        ovf_err;
    logic        und_err;

    int n_checks = 0;
    int n_fail   = 0;

    stack_unit #(.DATA_W(16), .DEPTH(32), .ADDR_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .push_src   (push_src),
        .data_in    (data_in),
        .alu_result (alu_result),
        .err_clr    (err_clr),
        .cmd_ready  (cmd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .full       (full),
        .empty      (empty),
        .depth      (depth),
        .ovf_err    (ovf_err),
        .und_err    (und_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    // Every call starts and ends 1 ns after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_push(input logic src, input logic [15:0] d, input logic [15:0] a);
        cmd_valid = 1'b1; cmd_op = C_PUSH; push_src = src; data_in = d; alu_result = a;
        step();
        cmd_valid = 1'b0; cmd_op = C_NOP; push_src = 1'b0;
    endtask

    // Issues a POP/PEEK and records rd_valid/cmd_ready over the next three cycles.
    task automatic do_read(input logic [1:0] op, output logic rv1, output logic rdy1,
                           output logic rv2, output logic [15:0] data2, output logic rv3,
                           output logic rdy3);
        cmd_valid = 1'b1; cmd_op = op;
        step();
        cmd_valid = 1'b0; cmd_op = C_NOP;
        rv1 = rd_valid; rdy1 = cmd_ready;
        step();
        rv2 = rd_valid; data2 = rd_data;
        step();
        rv3 = rd_valid; rdy3 = cmd_ready;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd_op = C_NOP; push_src = 1'b0;
        data_in = '0; alu_result = '0; err_clr = 1'b0;
        apply_reset();
        n_checks++; if (depth !== 6'd0) begin n_fail++; $display("FAIL reset_depth: got %0d expected 0", depth); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
        n_checks++; if (ovf_err !== 1'b0 || und_err !== 1'b0) begin n_fail++; $display("FAIL reset_errs: got ovf=%b und=%b expected 0 0", ovf_err, und_err); end
    endtask

    task automatic test_lifo();
        logic [15:0] exp_vals [3];
        logic rv1, rdy1, rv2, rv3, rdy3;
        logic [15:0] d2;
        exp_vals = '{16'h0033, 16'h0022, 16'h0011};
        do_push(1'b0, 16'h0011, 16'hFFFF);
        n_checks++; if (depth !== 6'd1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lifo_push1: got depth=%0d ready=%b expected 1 1", depth, cmd_ready); end
        do_push(1'b0, 16'h0022, 16'hFFFF);
        do_push(1'b0, 16'h0033, 16'hFFFF);
        n_checks++; if (depth !== 6'd3) begin n_fail++; $display("FAIL lifo_depth3: got %0d expected 3", depth); end
        for (int i = 0; i < 3; i++) begin
            do_read(C_POP, rv1, rdy1, rv2, d2, rv3, rdy3);
            n_checks++; if (rv1 !== 1'b0 || rdy1 !== 1'b0) begin n_fail++; $display("FAIL lifo_rd_cycle1[%0d]: got rd_valid=%b ready=%b expected 0 0", i, rv1, rdy1); end
            n_checks++; if (rv2 !== 1'b1) begin n_fail++; $display("FAIL lifo_latency[%0d]: got rd_valid=%b at N+2 expected 1", i, rv2); end
            n_checks++; if (d2 !== exp_vals[i]) begin n_fail++; $display("FAIL lifo_data[%0d]: got %h expected %h", i, d2, exp_vals[i]); end
            n_checks++; if (rv3 !== 1'b0 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL lifo_pulse[%0d]: got rd_valid=%b ready=%b expected 0 1", i, rv3, rdy3); end
            n_checks++; if (depth !== 6'(2 - i)) begin n_fail++; $display("FAIL lifo_depth_after[%0d]: got %0d expected %0d", i, depth, 2 - i); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty: got %b expected 1", empty); end
        n_checks++; if (rd_data !== 16'h0011) begin n_fail++; $display("FAIL lifo_hold: got %h expected 0011", rd_data); end
    endtask

    task automatic test_source();
        logic rv1, rdy1, rv2, rv3, rdy3;
        logic [15:0] d2;
        do_push(1'b1, 16'h1234, 16'hBEEF);
        do_push(1'b0, 16'h1234, 16'hBEEF);
        do_read(C_POP, rv1, rdy1, rv2, d2, rv3, rdy3);
        n_checks++; if (rv2 !== 1'b1 || d2 !== 16'h1234) begin n_fail++; $display("FAIL src_data: got vld=%b data=%h expected 1 1234", rv2, d2); end
        do_read(C_POP, rv1, rdy1, rv2, d2, rv3, rdy3);
        n_checks++; if (rv2 !== 1'b1 || d2 !== 16'hBEEF) begin n_fail++; $display("FAIL src_alu: got vld=%b data=%h expected 1 BEEF", rv2, d2); end
    endtask

    task automatic test_full();
        logic rv1, rdy1, rv2, rv3, rdy3;
        logic [15:0] d2;
        // Back-to-back pushes with cmd_valid held high.
        cmd_valid = 1'b1; cmd_op = C_PUSH; push_src = 1'b0;
        for (int i = 0; i < 32; i++) begin
            data_in = 16'h0100 + 16'(i);
            step();
            if (i == 30) begin
                n_checks++; if (full !== 1'b0 || depth !== 6'd31) begin n_fail++; $display("FAIL full_at31: got full=%b depth=%0d expected 0 31", full, depth); end
            end
        end
        cmd_valid = 1'b0; cmd_op = C_NOP;
        n_checks++; if (full !== 1'b1 || depth !== 6'd32) begin n_fail++; $display("FAIL full_at32: got full=%b depth=%0d expected 1 32", full, depth); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b expected 0", ovf_err); end
        do_push(1'b0, 16'hDEAD, 16'h0000);
        n_checks++; if (ovf_err !== 1'b1 || depth !== 6'd32) begin n_fail++; $display("FAIL full_ovf: got ovf=%b depth=%0d expected 1 32", ovf_err, depth); end
        do_read(C_POP, rv1, rdy1, rv2, d2, rv3, rdy3);
        n_checks++; if (rv2 !== 1'b1 || d2 !== 16'h011F) begin n_fail++; $display("FAIL full_pop: got vld=%b data=%h expected 1 011F", rv2, d2); end
        n_checks++; if (full !== 1'b0 || depth !== 6'd31 || ovf_err !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got full=%b depth=%0d ovf=%b expected 0 31 1", full, depth, ovf_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL full_err_clr: got %b expected 0", ovf_err); end
        apply_reset();
    endtask

    task automatic test_empty();
        logic rv1, rdy1, rv2, rv3, rdy3;
        logic [15:0] d2;
        do_read(C_POP, rv1, rdy1, rv2, d2, rv3, rdy3);
        n_checks++; if (und_err !== 1'b1) begin n_fail++; $display("FAIL empty_und: got %b expected 1", und_err); end
        n_checks++; if (rv1 !== 1'b0 || rv2 !== 1'b0 || rv3 !== 1'b0) begin n_fail++; $display("FAIL empty_no_valid: got %b%b%b expected 000", rv1, rv2, rv3); end
        n_checks++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL empty_ready: got %b%b expected 11", rdy1, rdy3); end
        do_read(C_PEEK, rv1, rdy1, rv2, d2, rv3, rdy3);
        n_checks++; if (und_err !== 1'b1 || rv2 !== 1'b0 || depth !== 6'd0) begin n_fail++; $display("FAIL empty_peek: got und=%b vld=%b depth=%0d expected 1 0 0", und_err, rv2, depth); end
        err_clr = 1'b1;
        step();
        n_checks++; if (und_err !== 1'b0) begin n_fail++; $display("FAIL empty_clr: got %b expected 0", und_err); end
        // A new underflow in the same cycle as err_clr must win.
        cmd_valid = 1'b1; cmd_op = C_POP;
        step();
        cmd_valid = 1'b0; cmd_op = C_NOP; err_clr = 1'b0;
        n_checks++; if (und_err !== 1'b1) begin n_fail++; $display("FAIL empty_set_wins: got %b expected 1", und_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_peek();
        logic rv1, rdy1, rv2, rv3, rdy3;
        logic [15:0] d2;
        do_push(1'b0, 16'h00A5, 16'h0000);
        cmd_valid = 1'b1; cmd_op = C_PEEK;
        step();
        // Now in RD: this PUSH must be ignored.
        cmd_op = C_PUSH; data_in = 16'h5555;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL peek_busy: got ready=%b expected 0", cmd_ready); end
        step();
        cmd_valid = 1'b0; cmd_op = C_NOP;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h00A5) begin n_fail++; $display("FAIL peek_data: got vld=%b data=%h expected 1 00A5", rd_valid, rd_data); end
        step();
        n_checks++; if (depth !== 6'd1) begin n_fail++; $display("FAIL peek_depth: got %0d expected 1", depth); end
        do_read(C_POP, rv1, rdy1, rv2, d2, rv3, rdy3);
        n_checks++; if (rv2 !== 1'b1 || d2 !== 16'h00A5) begin n_fail++; $display("FAIL peek_pop: got vld=%b data=%h expected 1 00A5", rv2, d2); end
        n_checks++; if (depth !== 6'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL peek_final: got depth=%0d empty=%b expected 0 1", depth, empty); end
    endtask

    task automatic test_reset_mid();
        do_push(1'b0, 16'h0007, 16'h0000);
        cmd_valid = 1'b1; cmd_op = C_POP;
        step();
        cmd_valid = 1'b0; cmd_op = C_NOP;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", rd_valid); end
        n_checks++; if (depth !== 6'd0 || empty !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got depth=%0d empty=%b ready=%b expected 0 1 1", depth, empty, cmd_ready); end
        step();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin n_fail++; $display("FAIL rstmid_after: got vld=%b data=%h expected 0 0000", rd_valid, rd_data); end
    endtask

    initial begin
        reset = 1'b1;
        #1;
        test_reset();
        test_lifo();
        test_source();
        test_full();
        test_empty();
        test_peek();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
